// File: rtl/uart_tx_packetizer.sv
// Buffers one tlast-delimited payload, then emits SOF, LEN, payload, CSUM on a byte stream for uart_tx.
// Define UART_PKT_CRC8_EN to make the CSUM byte a CRC-8 (poly 0x07) over LEN and payload instead of a sum checksum.
module uart_tx_packetizer #(
  parameter int unsigned MAX_LEN  = 64,
  parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] input_axis_tdata,
  input  logic       input_axis_tvalid,
  output logic       input_axis_tready,
  input  logic       input_axis_tlast,
  output logic [7:0] output_axis_tdata,
  output logic       output_axis_tvalid,
  input  logic       output_axis_tready,
  output logic       busy,
  output logic       truncated
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_SOF,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       trunc_q, trunc_d;

  logic [7:0] pl_mem [MAX_LEN];
  logic       in_xfer;
  logic       out_xfer;
  logic       mem_we;

`ifdef UART_PKT_CRC8_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    trunc_d    = 1'b0;
    mem_we     = 1'b0;
    in_xfer    = input_axis_tvalid & in_ready_q;
    out_xfer   = out_valid_q & output_axis_tready;

    unique case (state_q)
      ST_FILL: begin
        if (in_xfer) begin
          mem_we  = 1'b1;
          count_d = count_q + 8'd1;
`ifndef UART_PKT_CRC8_EN
          chk_d   = chk_q + input_axis_tdata;
`endif
          if (input_axis_tlast || (count_d == 8'(MAX_LEN))) begin
            state_d    = ST_SOF;
            out_data_d = SOF_BYTE;
            trunc_d    = ~input_axis_tlast;
          end
        end
      end
      ST_SOF: begin
        if (out_xfer) begin
          state_d    = ST_LEN;
          out_data_d = count_q;
        end
      end
      ST_LEN: begin
        if (out_xfer) begin
          state_d    = ST_PAYLOAD;
          idx_d      = '0;
          out_data_d = pl_mem[0];
`ifdef UART_PKT_CRC8_EN
          chk_d      = crc8_step(8'h00, count_q);
`endif
        end
      end
      ST_PAYLOAD: begin
        if (out_xfer) begin
`ifdef UART_PKT_CRC8_EN
          chk_d = crc8_step(chk_q, out_data_q);
`endif
          if (idx_q == count_q - 8'd1) begin
            state_d = ST_CSUM;
`ifdef UART_PKT_CRC8_EN
            out_data_d = chk_d;
`else
            out_data_d = 8'd0 - (count_q + chk_q);
`endif
          end else begin
            // Next byte is looked up here so the registered output stays one byte per cycle.
            idx_d      = idx_q + 8'd1;
            out_data_d = pl_mem[idx_d[AW-1:0]];
          end
        end
      end
      ST_CSUM: begin
        if (out_xfer) begin
          state_d    = ST_FILL;
          count_d    = '0;
          chk_d      = '0;
          idx_d      = '0;
          out_data_d = '0;
        end
      end
    endcase

    out_valid_d = (state_d != ST_FILL);
    busy_d      = (state_d != ST_FILL);
    in_ready_d  = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      trunc_q     <= trunc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pl_mem[count_q[AW-1:0]] <= input_axis_tdata;
    end
  end

  assign input_axis_tready  = in_ready_q;
  assign output_axis_tdata  = out_data_q;
  assign output_axis_tvalid = out_valid_q;
  assign busy               = busy_q;
  assign truncated          = trunc_q;

endmodule
